// File: rtl/wt_dcache_refill_writer.sv
// Refill write master for the data cache's full-cacheline write port.
// Collects refill beats critical-word-first into a line buffer and issues a
// single-cycle cacheline write. Invalidation writes are merged onto the same
// port combinationally whenever no refill write is in progress.
// Optional build macro: WT_REFILL_PERF_EN enables saturating refill/error counters.
module wt_dcache_refill_writer #(
  parameter int LINE_WIDTH = 128,
  parameter int BEAT_WIDTH = 64,
  parameter int SET_ASSOC  = 4,
  parameter int TAG_WIDTH  = 20,
  parameter int IDX_WIDTH  = 8,
  parameter int OFF_WIDTH  = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [TAG_WIDTH-1:0]    req_tag_i,
  input  logic [IDX_WIDTH-1:0]    req_idx_i,
  input  logic [OFF_WIDTH-1:0]    req_off_i,
  input  logic [SET_ASSOC-1:0]    req_way_i,
  input  logic                    req_nc_i,
  input  logic                    beat_valid_i,
  output logic                    beat_ready_o,
  input  logic [BEAT_WIDTH-1:0]   beat_data_i,
  input  logic                    beat_err_i,
  input  logic                    inval_valid_i,
  output logic                    inval_ready_o,
  input  logic [IDX_WIDTH-1:0]    inval_idx_i,
  input  logic [SET_ASSOC-1:0]    inval_way_i,
  output logic                    wr_cl_vld_o,
  output logic                    wr_cl_nc_o,
  output logic [SET_ASSOC-1:0]    wr_cl_we_o,
  output logic [TAG_WIDTH-1:0]    wr_cl_tag_o,
  output logic [IDX_WIDTH-1:0]    wr_cl_idx_o,
  output logic [OFF_WIDTH-1:0]    wr_cl_off_o,
  output logic [LINE_WIDTH-1:0]   wr_cl_data_o,
  output logic [LINE_WIDTH/8-1:0] wr_cl_data_be_o,
  output logic [SET_ASSOC-1:0]    wr_vld_bits_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic [31:0]             perf_refills_o,
  output logic [31:0]             perf_errs_o
);

  localparam int NBEATS     = LINE_WIDTH / BEAT_WIDTH;
  localparam int BEAT_BYTES = BEAT_WIDTH / 8;
  localparam int BOFF       = $clog2(BEAT_BYTES);
  localparam int SLOT_W     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [SLOT_W-1:0] CNT_LAST = SLOT_W'(NBEATS - 1);

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_e;

  state_e                  state_q;
  logic [TAG_WIDTH-1:0]    tag_q;
  logic [IDX_WIDTH-1:0]    idx_q;
  logic [OFF_WIDTH-1:0]    off_q;
  logic [SET_ASSOC-1:0]    way_q;
  logic                    nc_q;
  logic [SLOT_W-1:0]       start_q;
  logic [SLOT_W-1:0]       cnt_q;
  logic                    errf_q;
  logic [LINE_WIDTH-1:0]   line_q;
  logic [LINE_WIDTH/8-1:0] line_be_q;

  logic                    req_rdy_q, beat_rdy_q, inval_rdy_q;
  logic                    wr_vld_q, wr_nc_q, done_q, err_pulse_q;
  logic [SET_ASSOC-1:0]    wr_we_q, wr_vbits_q;
  logic [LINE_WIDTH/8-1:0] wr_be_q;

  logic [LINE_WIDTH-1:0]   line_d;
  logic [LINE_WIDTH/8-1:0] line_be_d;
  logic                    errf_d;
  logic [SLOT_W-1:0]       slot;
  logic [SLOT_W-1:0]       req_slot;
  logic                    beat_hs, last_beat, inval_hs;

  assign slot      = start_q + cnt_q;
  // Shift then truncate so the NBEATS==1 case (no slot bits in the offset) yields 0.
  assign req_slot  = SLOT_W'(req_off_i >> BOFF);
  assign beat_hs   = beat_valid_i & beat_rdy_q;
  assign last_beat = nc_q | (cnt_q == CNT_LAST);
  assign inval_hs  = inval_valid_i & inval_rdy_q;

  // Merge the incoming beat into its critical-word-first slot.
  always_comb begin
    line_d    = line_q;
    line_be_d = line_be_q;
    errf_d    = errf_q | beat_err_i;
    for (int unsigned s = 0; s < NBEATS; s++) begin
      if (32'(slot) == s) begin
        line_d[s*BEAT_WIDTH +: BEAT_WIDTH] = beat_data_i;
        line_be_d[s*BEAT_BYTES +: BEAT_BYTES] = '1;
      end
    end
  end

  // Refill FSM with registered handshake and write-strobe outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      tag_q       <= '0;
      idx_q       <= '0;
      off_q       <= '0;
      way_q       <= '0;
      nc_q        <= 1'b0;
      start_q     <= '0;
      cnt_q       <= '0;
      errf_q      <= 1'b0;
      line_q      <= '0;
      line_be_q   <= '0;
      req_rdy_q   <= 1'b1;
      beat_rdy_q  <= 1'b0;
      inval_rdy_q <= 1'b1;
      wr_vld_q    <= 1'b0;
      wr_nc_q     <= 1'b0;
      wr_we_q     <= '0;
      wr_vbits_q  <= '0;
      wr_be_q     <= '0;
      done_q      <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      wr_vld_q    <= 1'b0;
      wr_nc_q     <= 1'b0;
      wr_we_q     <= '0;
      wr_vbits_q  <= '0;
      wr_be_q     <= '0;
      done_q      <= 1'b0;
      err_pulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid_i && req_rdy_q) begin
            tag_q      <= req_tag_i;
            idx_q      <= req_idx_i;
            off_q      <= req_off_i;
            way_q      <= req_way_i;
            nc_q       <= req_nc_i;
            start_q    <= req_slot;
            cnt_q      <= '0;
            errf_q     <= 1'b0;
            line_q     <= '0;
            line_be_q  <= '0;
            req_rdy_q  <= 1'b0;
            beat_rdy_q <= 1'b1;
            state_q    <= FILL;
          end
        end
        FILL: begin
          if (beat_hs) begin
            line_q    <= line_d;
            line_be_q <= line_be_d;
            errf_q    <= errf_d;
            cnt_q     <= cnt_q + SLOT_W'(1);
            if (last_beat) begin
              state_q     <= WRITE;
              beat_rdy_q  <= 1'b0;
              inval_rdy_q <= 1'b0;
              wr_vld_q    <= 1'b1;
              done_q      <= 1'b1;
              err_pulse_q <= errf_d;
              wr_nc_q     <= nc_q;
              wr_be_q     <= line_be_d;
              wr_we_q     <= (nc_q || errf_d) ? '0 : way_q;
              wr_vbits_q  <= (nc_q || errf_d) ? '0 : way_q;
            end
          end
        end
        WRITE: begin
          state_q     <= IDLE;
          req_rdy_q   <= 1'b1;
          inval_rdy_q <= 1'b1;
        end
        default: begin
          state_q     <= IDLE;
          req_rdy_q   <= 1'b1;
          beat_rdy_q  <= 1'b0;
          inval_rdy_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready_o   = req_rdy_q;
  assign beat_ready_o  = beat_rdy_q;
  assign inval_ready_o = inval_rdy_q;

  // Invalidations can only be accepted outside WRITE, so they never collide
  // with a refill write; the registered strobes are all zero whenever they win.
  assign wr_cl_vld_o     = wr_vld_q | inval_hs;
  assign wr_cl_nc_o      = wr_nc_q;
  assign wr_cl_we_o      = inval_hs ? inval_way_i : wr_we_q;
  assign wr_cl_tag_o     = inval_hs ? '0 : tag_q;
  assign wr_cl_idx_o     = inval_hs ? inval_idx_i : idx_q;
  assign wr_cl_off_o     = inval_hs ? '0 : off_q;
  assign wr_cl_data_o    = line_q;
  assign wr_cl_data_be_o = wr_be_q;
  assign wr_vld_bits_o   = wr_vbits_q;
  assign done_o          = done_q;
  assign err_o           = err_pulse_q;

`ifdef WT_REFILL_PERF_EN
  logic [31:0] perf_refills_q, perf_errs_q;

  // Saturating counters of completed and errored refills.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_refills_q <= '0;
      perf_errs_q    <= '0;
    end else begin
      if (done_q && (perf_refills_q != '1)) perf_refills_q <= perf_refills_q + 32'd1;
      if (err_pulse_q && (perf_errs_q != '1)) perf_errs_q <= perf_errs_q + 32'd1;
    end
  end

  assign perf_refills_o = perf_refills_q;
  assign perf_errs_o    = perf_errs_q;
`else
  assign perf_refills_o = '0;
  assign perf_errs_o    = '0;
`endif

endmodule
